cv32e40s_cg_enable_ctrl: RTL

Sequential controller that generates the enable for the core clock gate cell (cv32e40s_clock_gate en_i). It owns the sleep handshake:
- takes a sleep request from the controller;
- waits until the pipeline is idle;
- drops the gate enable;
- restores the clock on a wake event, then holds the core in sleep for a settling window before release.

It runs on the free-running (ungated) clock, next to the clock gate in the sleep unit.

---
 rtl/cv32e40s_pkg.sv | 4 +
 rtl/cv32e40s_cg_enable_ctrl.sv | 111 +++++++++++
 2 files changed

// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg: shared types for the cv32e40s sleep unit
package cv32e40s_pkg;
  typedef enum logic [1:0] {CG_RUN, CG_DRAIN, CG_SLEEP, CG_WAKE} cg_ctrl_state_e;
endpackage

// File: rtl/cv32e40s_cg_enable_ctrl.sv
// cv32e40s_cg_enable_ctrl: sleep handshake and registered enable for the core clock gate
module cv32e40s_cg_enable_ctrl
  import cv32e40s_pkg::*;
#(
  parameter int IDLE_CYCLES = 2,
  parameter int WAKE_DELAY  = 2,
  parameter int SLEEP_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sleep_req_i,
  input  logic                   core_idle_i,
  input  logic                   wake_i,
  output logic                   clk_gate_en_o,
  output logic                   core_sleep_o,
  output logic                   sleep_abort_o,
  output logic                   wake_ack_o,
  output logic [SLEEP_CNT_W-1:0] sleep_cnt_o
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_DELAY + 1);

  if (IDLE_CYCLES < 1) begin : g_idle_chk
    $error("IDLE_CYCLES must be >= 1");
  end
  if (WAKE_DELAY < 1) begin : g_wake_chk
    $error("WAKE_DELAY must be >= 1");
  end

  cg_ctrl_state_e         state_q, state_d;
  logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]          wake_cnt_q, wake_cnt_d;
  logic [SLEEP_CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
  logic                   en_q, slp_q, abort_q, abort_d, ack_q, ack_d;
  logic                   idle_done, wake_done;

  assign idle_done = core_idle_i && idle_cnt_q == IW'(IDLE_CYCLES - 1);
  assign wake_done = wake_cnt_q == WW'(WAKE_DELAY - 1);

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    abort_d     = 1'b0;
    ack_d       = 1'b0;
    sleep_cnt_d = (state_q == CG_SLEEP && !(&sleep_cnt_q)) ? sleep_cnt_q + 1'b1 : sleep_cnt_q;
    case (state_q)
      CG_RUN: begin
        if (sleep_req_i && !wake_i) begin
          state_d    = CG_DRAIN;
          idle_cnt_d = '0;
        end
      end
      CG_DRAIN: begin
        // idle streak must be consecutive: any busy cycle restarts it
        idle_cnt_d = !core_idle_i ? '0 :
                     (idle_cnt_q == IW'(IDLE_CYCLES)) ? idle_cnt_q : idle_cnt_q + 1'b1;
        if (wake_i) begin
          state_d = CG_RUN;
          abort_d = 1'b1;
        end else if (!sleep_req_i) begin
          state_d = CG_RUN;
        end else if (idle_done) begin
          state_d = CG_SLEEP;
        end
      end
      CG_SLEEP: begin
        if (wake_i) begin
          state_d    = CG_WAKE;
          wake_cnt_d = '0;
        end
      end
      CG_WAKE: begin
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_done) begin
          state_d = CG_RUN;
          ack_d   = 1'b1;
        end
      end
      default: state_d = CG_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CG_RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      sleep_cnt_q <= '0;
      en_q        <= 1'b1;
      slp_q       <= 1'b0;
      abort_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      sleep_cnt_q <= sleep_cnt_d;
      en_q        <= state_d != CG_SLEEP;
      slp_q       <= state_d == CG_SLEEP || state_d == CG_WAKE;
      abort_q     <= abort_d;
      ack_q       <= ack_d;
    end
  end

  assign clk_gate_en_o = en_q;
  assign core_sleep_o  = slp_q;
  assign sleep_abort_o = abort_q;
  assign wake_ack_o    = ack_q;
  assign sleep_cnt_o   = sleep_cnt_q;
endmodule
